bin2bcd_seg: RTL and testbench
==============================

// Module: bin2bcd_seg
// PURPOSE
//  Converts an unsigned binary sample, e.g. an 8-bit ADC result from the I2C reader, into the
//  32-bit packed nibble word that the seven-segment display driver takes on its seg_val input.
//  Uses a sequential double-dabble (shift/add-3) engine: one bit per clock, no divider/modulo logic.
//  Suppresses leading zeros and puts a fixed prefix symbol in the leftmost digit.
//  Sits between the ADC read stage (rd_data/rd_data_vld) and the seg display stage.
// PARAMETERS
//  BIN_W        8      width of bin_data; legal 1..23
//  BCD_DIGITS   3      BCD digits produced; must satisfy 10**BCD_DIGITS > 2**BIN_W-1 and be <= 7
//  PREFIX_CODE  4'hF   nibble placed in seg_val[31:28] (display prefix symbol)
//  BLANK_CODE   4'hA   nibble the display driver renders as an unlit digit
// PORTS
//  sys_clk      in   1                 system clock, all logic on rising edge
//  sys_rst_n    in   1                 asynchronous active-low reset
//  bin_data     in   BIN_W             unsigned value to convert, sampled when bin_vld=1 and busy=0
//  bin_vld      in   1                 request strobe, single cycle or level
//  busy         out  1                 conversion in progress; requests are dropped while high
//  seg_val      out  32                {PREFIX_CODE, 7 digit nibbles}; digit 0 is in [3:0]
//  seg_val_vld  out  1                 one-cycle pulse when seg_val takes a new value
// BEHAVIOUR
//  Reset (async, any state):
//   - FSM goes to IDLE; busy=0; seg_val_vld=0.
//   - seg_val={PREFIX_CODE,{7{BLANK_CODE}}}, i.e. 32'hFAAA_AAAA at defaults.
//  FSM states: IDLE -> SHIFT -> FMT -> OUT -> IDLE.
//   - IDLE: on an edge with bin_vld=1, latch bin_data into the shift reg, clear the BCD accumulator,
//     load bit counter=BIN_W-1, go to SHIFT, set busy=1.
//   - SHIFT: exactly BIN_W edges. Each edge: add 3 to every BCD nibble >=5 (combinational,
//     same cycle), then shift {bcd,bin} left by 1. Leave when the counter reaches 0 (no wrap).
//   - FMT: 1 edge. Scan from the most significant digit. Each leading zero digit becomes
//     BLANK_CODE; stop at the first non-zero digit. Digit 0 is never blanked, so value 0 shows "0".
//     Digits above BCD_DIGITS (up to position 6) are always BLANK_CODE. Result goes to a staging reg.
//   - OUT: 1 edge. seg_val <= staging; seg_val_vld <= 1 for that one cycle; busy <= 0; go to IDLE.
//  Latency:
//   - Request sampled on edge k; seg_val/seg_val_vld update on edge k+BIN_W+2 (10 at defaults).
//   - busy is high from after edge k until edge k+BIN_W+2.
//   - A new request can be accepted on the edge right after seg_val_vld rises.
//  Holding and dropping:
//   - seg_val holds its last value between conversions and never shows intermediate data.
//   - bin_vld while busy=1 is ignored, not queued. bin_data may change freely after sampling.
//  Level bin_vld: tied high, the block converts back-to-back (one result every BIN_W+3 cycles).
//  Reset mid-conversion: abort, no seg_val_vld pulse, outputs take their reset values.
//  Width rule: BCD accumulator is 4*BCD_DIGITS bits. Elaboration fails via $error if the
//   BCD_DIGITS constraint is violated; there is no runtime overflow path.
// TESTING
//  1 Reset release, no request -> seg_val=32'hFAAA_AAAA, busy=0, seg_val_vld never pulses.
//  2 Single requests at defaults: 0->FAAAAAA0, 7->FAAAAAA7, 42->FAAAAA42, 100->FAAAA100,
//    255->FAAAA255. Each seg_val_vld pulse exactly 10 edges after the sampling edge, 1 cycle wide.
//  3 Exhaustive 0..255 sweep vs. a reference model (div/mod with blanking) -> zero mismatches,
//    exactly 256 vld pulses.
//  4 bin_vld=200 at edge 0, bin_vld=5 at edge 3 (busy) -> only FAAAA200 appears, one vld pulse.
//    Request 5 at edge 11 -> FAAAAAA5 at edge 21.
//  5 bin_vld held high, bin_data=9 -> a vld pulse every 11 cycles, seg_val stable at FAAAAAA9.
//  6 sys_rst_n low at edge 5 of converting 99 -> immediate FAAAAAAA, busy=0, no pulse.
//    After release, request 99 -> FAAAAA99 after 10 edges.

Source files
------------

// File: rtl/bin2bcd_seg.sv
// Sequential double-dabble converter from an unsigned binary sample to a packed
// seven-segment nibble word: prefix symbol on the left, leading zeros blanked.
module bin2bcd_seg #(
  parameter int          BIN_W       = 8,
  parameter int          BCD_DIGITS  = 3,
  parameter logic [3:0]  PREFIX_CODE = 4'hF,
  parameter logic [3:0]  BLANK_CODE  = 4'hA
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [BIN_W-1:0]  bin_data,
  input  logic              bin_vld,
  output logic              busy,
  output logic [31:0]       seg_val,
  output logic              seg_val_vld
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam longint unsigned MAX_BIN   = (64'd1 << BIN_W) - 64'd1;
  localparam longint unsigned DEC_RANGE = 64'd10 ** BCD_DIGITS;
  localparam logic [31:0] SEG_RST = {PREFIX_CODE, {7{BLANK_CODE}}};

  if (BIN_W < 1 || BIN_W > 23 || BCD_DIGITS < 1 || BCD_DIGITS > 7 || DEC_RANGE <= MAX_BIN) begin : g_bad_cfg
    $error("bin2bcd_seg: BCD_DIGITS too small for BIN_W, or parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, FMT, OUT} state_t;

  state_t               state_r, state_nxt_s;
  logic [BIN_W-1:0]     bin_r;
  logic [BCD_W-1:0]     bcd_r;
  logic [BCD_W-1:0]     adj_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [31:0]          stage_r;
  logic [31:0]          fmt_s;
  logic [27:0]          ext_s;
  logic                 lead_s;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  assign adj_s = add3(bcd_r);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (bin_vld) state_nxt_s = SHIFT; else state_nxt_s = IDLE;
      SHIFT:   if (cnt_r == {CNT_W{1'b0}}) state_nxt_s = FMT; else state_nxt_s = SHIFT;
      FMT:     state_nxt_s = OUT;
      OUT:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Leading-zero blanking, scanning from the top digit; digit 0 always shows
  always_comb begin
    ext_s = 28'd0;
    ext_s[BCD_W-1:0] = bcd_r;
    lead_s = 1'b1;
    fmt_s = {PREFIX_CODE, 28'd0};
    for (int i = 6; i >= 0; i--) begin
      if (i >= BCD_DIGITS) begin
        fmt_s[4*i +: 4] = BLANK_CODE;
      end else if (lead_s && (i != 0) && (ext_s[4*i +: 4] == 4'd0)) begin
        fmt_s[4*i +: 4] = BLANK_CODE;
      end else begin
        lead_s = 1'b0;
        fmt_s[4*i +: 4] = ext_s[4*i +: 4];
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_r       <= {BIN_W{1'b0}};
      bcd_r       <= {BCD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      stage_r     <= SEG_RST;
      seg_val     <= SEG_RST;
      seg_val_vld <= 1'b0;
      busy        <= 1'b0;
    end else begin
      seg_val_vld <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bin_vld) begin
            bin_r <= bin_data;
            bcd_r <= {BCD_W{1'b0}};
            cnt_r <= CNT_W'(BIN_W - 1);
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          {bcd_r, bin_r} <= {adj_s[BCD_W-2:0], bin_r, 1'b0};
          if (cnt_r != {CNT_W{1'b0}}) cnt_r <= cnt_r - 1'b1;
        end
        FMT: stage_r <= fmt_s;
        OUT: begin
          seg_val     <= stage_r;
          seg_val_vld <= 1'b1;
          busy        <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seg.sv
// Directed self-checking bench for bin2bcd_seg at default parameters.
module tb_bin2bcd_seg;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  bin_data;
  logic        bin_vld;
  logic        busy;
  logic [31:0] seg_val;
  logic        seg_val_vld;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_exp;

  bin2bcd_seg dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .bin_data    (bin_data),
    .bin_vld     (bin_vld),
    .busy        (busy),
    .seg_val     (seg_val),
    .seg_val_vld (seg_val_vld)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference: decimal digits by div/mod, leading zeros blanked.
  function automatic logic [31:0] ref_seg(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {4'hF, 4'hA, 4'hA, 4'hA, 4'hA,
            (h == 4'd0) ? 4'hA : h,
            (h == 4'd0 && t == 4'd0) ? 4'hA : t,
            o};
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    int pulses;
    pulses = 0;
    n_checks++;
    if (seg_val !== 32'hFAAA_AAAA) begin n_fail++; $display("FAIL reset_seg got=%h exp=FAAAAAAA", seg_val); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (seg_val_vld === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL reset_no_pulse got=%0d exp=0", pulses); end
    n_checks++;
    if (seg_val !== 32'hFAAA_AAAA || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle seg=%h busy=%b exp=FAAAAAAA/0", seg_val, busy);
    end
    last_exp = 32'hFAAA_AAAA;
  endtask

  task automatic test_single();
    int vals [5] = '{0, 7, 42, 100, 255};
    logic [31:0] exps [5] = '{32'hFAAA_AAA0, 32'hFAAA_AAA7, 32'hFAAA_AA42, 32'hFAAA_A100, 32'hFAAA_A255};
    int lat;
    int held_bad;
    for (int k = 0; k < 5; k++) begin
      bin_data = 8'(vals[k]);
      bin_vld = 1'b1;
      step();
      bin_vld = 1'b0;
      bin_data = 8'hFF;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy v=%0d got=%b exp=1", vals[k], busy); end
      lat = 0;
      held_bad = 0;
      for (int n = 1; n <= 20; n++) begin
        step();
        if (seg_val_vld === 1'b1) begin lat = n; break; end
        if (seg_val !== last_exp) held_bad++;
      end
      n_checks++;
      if (lat !== 10) begin n_fail++; $display("FAIL single_latency v=%0d got=%0d exp=10", vals[k], lat); end
      n_checks++;
      if (held_bad !== 0) begin n_fail++; $display("FAIL single_hold v=%0d got=%0d exp=0", vals[k], held_bad); end
      n_checks++;
      if (seg_val !== exps[k]) begin n_fail++; $display("FAIL single_value v=%0d got=%h exp=%h", vals[k], seg_val, exps[k]); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_clr v=%0d got=%b exp=0", vals[k], busy); end
      step();
      n_checks++;
      if (seg_val_vld !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width v=%0d got=%b exp=0", vals[k], seg_val_vld); end
      last_exp = exps[k];
    end
  endtask

  task automatic test_sweep();
    int pulses;
    int bad;
    pulses = 0;
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      bin_data = 8'(v);
      bin_vld = 1'b1;
      step();
      bin_vld = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        step();
        if (seg_val_vld === 1'b1) break;
      end
      if (seg_val_vld === 1'b1) pulses++;
      if (seg_val !== ref_seg(v)) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL sweep_values got=%0d bad exp=0", bad); end
    n_checks++;
    if (pulses !== 256) begin n_fail++; $display("FAIL sweep_pulses got=%0d exp=256", pulses); end
    last_exp = ref_seg(255);
  endtask

  task automatic test_drop();
    int pulses;
    int lat;
    bin_data = 8'd200;
    bin_vld = 1'b1;
    step();                       // edge 0
    bin_vld = 1'b0;
    step();                       // edge 1
    step();                       // edge 2
    bin_data = 8'd5;
    bin_vld = 1'b1;
    step();                       // edge 3, busy -> dropped
    bin_vld = 1'b0;
    pulses = 0;
    for (int e = 4; e <= 10; e++) begin
      step();
      if (seg_val_vld === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 1 || seg_val_vld !== 1'b1) begin
      n_fail++; $display("FAIL drop_pulse got=%0d vld_at10=%b exp=1/1", pulses, seg_val_vld);
    end
    n_checks++;
    if (seg_val !== 32'hFAAA_A200) begin n_fail++; $display("FAIL drop_value got=%h exp=FAAAA200", seg_val); end
    bin_data = 8'd5;
    bin_vld = 1'b1;
    step();                       // edge 11
    bin_vld = 1'b0;
    lat = 0;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (seg_val_vld === 1'b1) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
    n_checks++;
    if (lat !== 10 || pulses !== 1) begin n_fail++; $display("FAIL drop_second_latency got=%0d/%0d exp=10/1", lat, pulses); end
    n_checks++;
    if (seg_val !== 32'hFAAA_AAA5) begin n_fail++; $display("FAIL drop_second_value got=%h exp=FAAAAAA5", seg_val); end
    last_exp = 32'hFAAA_AAA5;
  endtask

  task automatic test_back_to_back();
    int pulses;
    int off_grid;
    int bad_val;
    pulses = 0;
    off_grid = 0;
    bad_val = 0;
    bin_data = 8'd9;
    bin_vld = 1'b1;
    step();                       // edge 0
    for (int e = 1; e <= 45; e++) begin
      step();
      if (seg_val_vld === 1'b1) begin
        pulses++;
        if ((e - 10) % 11 != 0) off_grid++;
      end
      if (e >= 10 && seg_val !== 32'hFAAA_AAA9) bad_val++;
    end
    bin_vld = 1'b0;
    n_checks++;
    if (pulses !== 4) begin n_fail++; $display("FAIL level_pulses got=%0d exp=4", pulses); end
    n_checks++;
    if (off_grid !== 0) begin n_fail++; $display("FAIL level_period got=%0d off-grid exp=0", off_grid); end
    n_checks++;
    if (bad_val !== 0) begin n_fail++; $display("FAIL level_value got=%0d bad exp=0", bad_val); end
    for (int n = 0; n < 30; n++) begin
      if (busy === 1'b0) break;
      step();
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL level_drain got=%b exp=0", busy); end
    step();
    last_exp = 32'hFAAA_AAA9;
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    bin_data = 8'd99;
    bin_vld = 1'b1;
    step();                       // edge 0
    bin_vld = 1'b0;
    for (int e = 1; e <= 5; e++) step();
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (seg_val !== 32'hFAAA_AAAA || busy !== 1'b0 || seg_val_vld !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs seg=%h busy=%b vld=%b exp=FAAAAAAA/0/0", seg_val, busy, seg_val_vld);
    end
    pulses = 0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (seg_val_vld === 1'b1) pulses++;
    end
    sys_rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      if (seg_val_vld === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_no_pulse got=%0d busy=%b exp=0/0", pulses, busy); end
    bin_data = 8'd99;
    bin_vld = 1'b1;
    step();
    bin_vld = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (seg_val_vld === 1'b1) begin lat = n; break; end
    end
    n_checks++;
    if (lat !== 10) begin n_fail++; $display("FAIL midreset_latency got=%0d exp=10", lat); end
    n_checks++;
    if (seg_val !== 32'hFAAA_AA99) begin n_fail++; $display("FAIL midreset_value got=%h exp=FAAAAA99", seg_val); end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    bin_data = 8'd0;
    bin_vld = 1'b0;
    last_exp = 32'hFAAA_AAAA;
    #22;
    test_reset();
    test_single();
    test_sweep();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
